// File: rtl/reorder_buffer.sv
// In-order retirement queue: entries are allocated at the tail, completed out of order
// through the writeback ports, and retired from the head one per cycle.
module reorder_buffer #(
  parameter int DEPTH    = 16,
  parameter int WB_PORTS = 3,
  localparam int IDX_W   = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [1:0]                issue_kind,
  input  logic [4:0]                issue_rd,
  input  logic [31:0]               issue_pc,
  input  logic                      issue_pred_taken,
  input  logic                      issue_done,
  input  logic [31:0]               issue_value,
  output logic [IDX_W-1:0]          issue_id,
  input  logic [WB_PORTS-1:0]       wb_valid,
  input  logic [WB_PORTS*IDX_W-1:0] wb_id,
  input  logic [WB_PORTS*32-1:0]    wb_value,
  input  logic [WB_PORTS-1:0]       wb_taken,
  input  logic [WB_PORTS*32-1:0]    wb_target,
  input  logic [IDX_W-1:0]          qry1_id,
  input  logic [IDX_W-1:0]          qry2_id,
  output logic                      qry1_ready,
  output logic [31:0]               qry1_value,
  output logic                      qry2_ready,
  output logic [31:0]               qry2_value,
  output logic                      commit_valid,
  output logic [4:0]                commit_rd,
  output logic [31:0]               commit_value,
  output logic                      commit_store,
  output logic                      flush,
  output logic [31:0]               flush_pc,
  output logic [IDX_W:0]            count,
  output logic                      empty
);
  localparam logic [1:0] K_REG = 2'd0, K_BR = 2'd1, K_ST = 2'd2, K_NOP = 2'd3;

  typedef enum logic [1:0] {ST_EMPTY, ST_ISSUED, ST_DONE} st_e;

  typedef struct packed {
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        pred;
    logic [31:0] value;
    logic        taken;
    logic [31:0] target;
  } ent_t;

  st_e              st     [DEPTH];
  ent_t             ent    [DEPTH];
  logic [IDX_W-1:0] head, tail;

  logic             wb_hit [DEPTH];
  logic [31:0]      wb_val [DEPTH];
  logic             wb_tk  [DEPTH];
  logic [31:0]      wb_tg  [DEPTH];

  logic head_done, mispredict, do_issue;

  assign issue_ready = count < (IDX_W+1)'(DEPTH);
  assign issue_id    = tail;
  assign empty       = (count == '0);
  assign head_done   = (st[head] == ST_DONE);
  assign mispredict  = head_done && ent[head].kind == K_BR && ent[head].taken != ent[head].pred;
  assign do_issue    = issue_valid && issue_ready && rdy && !mispredict;

  // Scan ports high to low so the lowest-numbered matching port is the last writer.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      wb_hit[e] = 1'b0;
      wb_val[e] = '0;
      wb_tk[e]  = 1'b0;
      wb_tg[e]  = '0;
      for (int p = WB_PORTS-1; p >= 0; p--) begin
        if (wb_valid[p] && wb_id[p*IDX_W +: IDX_W] == IDX_W'(e)) begin
          wb_hit[e] = 1'b1;
          wb_val[e] = wb_value[p*32 +: 32];
          wb_tk[e]  = wb_taken[p];
          wb_tg[e]  = wb_target[p*32 +: 32];
        end
      end
    end
  end

  always_comb begin
    qry1_ready = 1'b0;
    qry1_value = '0;
    if (st[qry1_id] == ST_DONE) begin
      qry1_ready = 1'b1;
      qry1_value = ent[qry1_id].value;
    end else if (st[qry1_id] == ST_ISSUED && wb_hit[qry1_id]) begin
      qry1_ready = 1'b1;
      qry1_value = wb_val[qry1_id];
    end
  end

  always_comb begin
    qry2_ready = 1'b0;
    qry2_value = '0;
    if (st[qry2_id] == ST_DONE) begin
      qry2_ready = 1'b1;
      qry2_value = ent[qry2_id].value;
    end else if (st[qry2_id] == ST_ISSUED && wb_hit[qry2_id]) begin
      qry2_ready = 1'b1;
      qry2_value = wb_val[qry2_id];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      commit_valid <= 1'b0;
      commit_rd    <= '0;
      commit_value <= '0;
      commit_store <= 1'b0;
      flush        <= 1'b0;
      flush_pc     <= '0;
      for (int e = 0; e < DEPTH; e++) st[e] <= ST_EMPTY;
    end else if (!rdy) begin
      commit_valid <= 1'b0;
      commit_store <= 1'b0;
      flush        <= 1'b0;
    end else begin
      commit_valid <= head_done;
      commit_store <= 1'b0;
      flush        <= 1'b0;
      if (head_done) begin
        commit_rd    <= (ent[head].kind == K_REG) ? ent[head].rd : 5'd0;
        commit_value <= ent[head].value;
        commit_store <= (ent[head].kind == K_ST);
      end
      for (int e = 0; e < DEPTH; e++) begin
        if (st[e] == ST_ISSUED && wb_hit[e]) begin
          st[e]        <= ST_DONE;
          ent[e].value <= wb_val[e];
          ent[e].taken <= wb_tk[e];
          ent[e].target <= wb_tg[e];
        end
      end
      if (do_issue) begin
        st[tail]  <= (issue_done || issue_kind == K_NOP) ? ST_DONE : ST_ISSUED;
        ent[tail] <= '{kind: issue_kind, rd: issue_rd, pc: issue_pc, pred: issue_pred_taken,
                       value: issue_value, taken: issue_pred_taken, target: 32'd0};
        tail      <= tail + IDX_W'(1);
      end
      if (head_done) begin
        st[head] <= ST_EMPTY;
        head     <= head + IDX_W'(1);
      end
      count <= count + (IDX_W+1)'(do_issue) - (IDX_W+1)'(head_done);
      // A mispredicted branch retiring discards everything younger, including this cycle's issue.
      if (mispredict) begin
        flush    <= 1'b1;
        flush_pc <= ent[head].taken ? ent[head].target : ent[head].pc + 32'd4;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        for (int e = 0; e < DEPTH; e++) st[e] <= ST_EMPTY;
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized and directed bench for reorder_buffer, scored against a queue-of-instructions model.
module tb_reorder_buffer;
  localparam int DEPTH = 16, WBP = 3, IW = 4;

  logic              clk = 1'b0;
  logic              rst, rdy, issue_valid, issue_pred_taken, issue_done;
  logic [1:0]        issue_kind;
  logic [4:0]        issue_rd;
  logic [31:0]       issue_pc, issue_value;
  logic [WBP-1:0]    wb_valid, wb_taken;
  logic [WBP*IW-1:0] wb_id;
  logic [WBP*32-1:0] wb_value, wb_target;
  logic [IW-1:0]     qry1_id, qry2_id, issue_id;
  logic              issue_ready, qry1_ready, qry2_ready;
  logic [31:0]       qry1_value, qry2_value, commit_value, flush_pc;
  logic              commit_valid, commit_store, flush, empty;
  logic [4:0]        commit_rd;
  logic [IW:0]       count;

  reorder_buffer #(.DEPTH(DEPTH), .WB_PORTS(WBP)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_kind(issue_kind),
    .issue_rd(issue_rd), .issue_pc(issue_pc), .issue_pred_taken(issue_pred_taken),
    .issue_done(issue_done), .issue_value(issue_value), .issue_id(issue_id),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value), .wb_taken(wb_taken),
    .wb_target(wb_target),
    .qry1_id(qry1_id), .qry2_id(qry2_id), .qry1_ready(qry1_ready), .qry1_value(qry1_value),
    .qry2_ready(qry2_ready), .qry2_value(qry2_value),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
    .commit_store(commit_store), .flush(flush), .flush_pc(flush_pc),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    int          kind;
    logic [4:0]  rd;
    logic [31:0] pc;
    bit          pred;
    bit          done;
    logic [31:0] value;
    bit          taken;
    logic [31:0] target;
  } ment_t;

  ment_t       q[$];
  int          mhead = 0;
  logic [31:0] clog[$];
  int          checks = 0, errors = 0;
  bit          exp_cv, exp_fl, exp_st, was_rst;
  logic [4:0]  exp_rd;
  logic [31:0] exp_val, exp_fpc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b1; rdy = 1'b1; issue_valid = 1'b0; issue_kind = 2'd0; issue_rd = '0;
    issue_pc = '0; issue_pred_taken = 1'b0; issue_done = 1'b0; issue_value = '0;
    wb_valid = '0; wb_id = '0; wb_value = '0; wb_taken = '0; wb_target = '0;
    qry1_id = '0; qry2_id = '0;
  endtask

  task automatic set_issue(input int kind, input int rd, input logic [31:0] pc, input bit pred,
                           input bit done, input logic [31:0] value);
    issue_valid = 1'b1; issue_kind = 2'(kind); issue_rd = 5'(rd); issue_pc = pc;
    issue_pred_taken = pred; issue_done = done; issue_value = value;
  endtask

  task automatic set_wb(input int p, input int id, input logic [31:0] v, input bit tk,
                        input logic [31:0] tg);
    wb_valid[p] = 1'b1; wb_id[p*IW +: IW] = IW'(id); wb_value[p*32 +: 32] = v;
    wb_taken[p] = tk; wb_target[p*32 +: 32] = tg;
  endtask

  // Expected query answer: finished entries report their result, pending ones see this cycle's writeback.
  task automatic qlook(input int id, output bit r, output logic [31:0] v);
    r = 1'b0; v = '0;
    foreach (q[i]) begin
      if (q[i].id == id) begin
        if (q[i].done) begin
          r = 1'b1; v = q[i].value;
        end else begin
          for (int p = WBP-1; p >= 0; p--)
            if (wb_valid[p] && int'(wb_id[p*IW +: IW]) == id) begin
              r = 1'b1; v = wb_value[p*32 +: 32];
            end
        end
      end
    end
  endtask

  task automatic cyc();
    int n; bit hd, mp, r; logic [31:0] v; ment_t m;
    @(negedge clk);
    n = q.size();
    chk("issue_ready", issue_ready, n < DEPTH);
    chk("issue_id", issue_id, 64'((mhead + n) % DEPTH));
    chk("count", count, 64'(n));
    chk("empty", empty, n == 0);
    qlook(int'(qry1_id), r, v);
    chk("qry1_ready", qry1_ready, r); chk("qry1_value", qry1_value, v);
    qlook(int'(qry2_id), r, v);
    chk("qry2_ready", qry2_ready, r); chk("qry2_value", qry2_value, v);
    was_rst = !rst;
    if (!rst) begin
      q.delete(); mhead = 0;
      exp_cv = 0; exp_fl = 0; exp_st = 0; exp_rd = '0; exp_val = '0; exp_fpc = '0;
    end else if (!rdy) begin
      exp_cv = 0; exp_fl = 0;
    end else begin
      hd = n > 0 && q[0].done;
      mp = hd && q[0].kind == 1 && q[0].taken != q[0].pred;
      exp_cv = hd; exp_fl = mp;
      if (hd) begin
        exp_rd = (q[0].kind == 0) ? q[0].rd : 5'd0;
        exp_val = q[0].value;
        exp_st = q[0].kind == 2;
      end
      if (mp) exp_fpc = q[0].taken ? q[0].target : q[0].pc + 32'd4;
      for (int i = 0; i < n; i++) begin
        if (!q[i].done) begin
          for (int p = 0; p < WBP; p++) begin
            if (wb_valid[p] && int'(wb_id[p*IW +: IW]) == q[i].id) begin
              m = q[i];
              m.done = 1; m.value = wb_value[p*32 +: 32];
              m.taken = wb_taken[p]; m.target = wb_target[p*32 +: 32];
              q[i] = m;
              break;
            end
          end
        end
      end
      if (issue_valid && n < DEPTH && !mp) begin
        m.id = (mhead + n) % DEPTH; m.kind = int'(issue_kind); m.rd = issue_rd;
        m.pc = issue_pc; m.pred = issue_pred_taken;
        m.done = issue_done || issue_kind == 2'd3; m.value = issue_value;
        m.taken = issue_pred_taken; m.target = '0;
        q.push_back(m);
      end
      if (hd) begin
        void'(q.pop_front());
        mhead = (mhead + 1) % DEPTH;
      end
      if (mp) begin
        q.delete(); mhead = 0;
      end
    end
    @(posedge clk); #1;
    chk("commit_valid", commit_valid, exp_cv);
    chk("flush", flush, exp_fl);
    if (exp_cv || was_rst) begin
      chk("commit_rd", commit_rd, exp_rd);
      chk("commit_value", commit_value, exp_val);
      chk("commit_store", commit_store, exp_st);
    end
    if (exp_fl || was_rst) chk("flush_pc", flush_pc, exp_fpc);
    if (commit_valid) clog.push_back(commit_value);
  endtask

  task automatic do_reset();
    idle(); rst = 1'b0; cyc(); idle();
  endtask

  initial begin
    idle(); rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0); chk("rst_empty", empty, 1);
    chk("rst_commit_valid", commit_valid, 0); chk("rst_flush", flush, 0);
    chk("rst_commit_rd", commit_rd, 0); chk("rst_commit_value", commit_value, 0);
    chk("rst_flush_pc", flush_pc, 0); chk("rst_commit_store", commit_store, 0);
    idle();

    // Fill to capacity with nothing completing; the extra issue must be dropped.
    for (int i = 0; i < DEPTH + 1; i++) begin
      idle(); set_issue(0, i + 1, 32'(i * 4), 0, 0, 32'hdead0000 + 32'(i)); cyc();
    end
    idle(); #1;
    chk("full_count", count, 16); chk("full_ready", issue_ready, 0);

    // Out-of-order completion, in-order retirement.
    do_reset(); clog.delete();
    for (int i = 0; i < 3; i++) begin
      idle(); set_issue(0, i + 1, 32'(i * 4), 0, 0, 0); cyc();
    end
    idle(); set_wb(0, 2, 32'h22, 0, 0); cyc();
    idle(); set_wb(0, 0, 32'h00, 0, 0); cyc();
    idle(); set_wb(0, 1, 32'h11, 0, 0); cyc();
    idle(); repeat (4) cyc();
    chk("ooo_ncommit", clog.size(), 3);
    if (clog.size() == 3) begin
      chk("ooo_c0", clog[0], 32'h00); chk("ooo_c1", clog[1], 32'h11); chk("ooo_c2", clog[2], 32'h22);
    end

    // Two ports on one id: the lower port's value is the one kept and bypassed.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      idle(); set_issue(0, 1, 0, 0, 0, 0); cyc();
    end
    idle(); set_wb(0, 5, 32'hA, 0, 0); set_wb(2, 5, 32'hB, 0, 0); qry1_id = 4'd5; #1;
    chk("wb_prio_bypass", qry1_value, 32'hA);
    cyc();
    idle(); qry1_id = 4'd5; #1;
    chk("wb_prio_ready", qry1_ready, 1); chk("wb_prio_held", qry1_value, 32'hA);

    // Mispredicted branch retires: redirect and drop everything, including a same-cycle issue.
    do_reset();
    idle(); set_issue(1, 0, 32'h100, 0, 0, 0); cyc();
    idle(); set_wb(0, 0, 0, 1, 32'h200); set_issue(0, 3, 32'h104, 0, 1, 7); cyc();
    idle(); set_issue(0, 4, 32'h108, 0, 1, 8); cyc();
    chk("mp_flush", flush, 1); chk("mp_flush_pc", flush_pc, 32'h200); chk("mp_count", count, 0);
    idle(); cyc();

    // Continuous stream through the pointers' wrap points.
    do_reset(); clog.delete();
    for (int i = 0; i < 40; i++) begin
      idle(); set_issue(0, 1, 32'(i * 4), 0, 1, 32'(i)); cyc();
      chk("stream_bound", count <= 16, 1);
    end
    idle(); repeat (3) cyc();
    chk("stream_ncommit", clog.size(), 40);
    foreach (clog[i]) chk("stream_order", clog[i], 32'(i));

    // Reset with live entries and a head ready to retire.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      idle(); set_issue(0, 2, 0, 0, 0, 0); cyc();
    end
    idle(); set_wb(1, 0, 32'h55, 0, 0); cyc();
    chk("pre_rst_count", count, 7);
    idle(); rst = 1'b0; set_issue(0, 1, 0, 0, 1, 1); set_wb(0, 1, 1, 0, 0); cyc();
    chk("live_rst_count", count, 0); chk("live_rst_empty", empty, 1);
    chk("live_rst_commit", commit_valid, 0);

    // Random traffic.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      int r;
      idle();
      rdy = $urandom_range(9) != 0;
      rst = $urandom_range(199) != 0;
      if ($urandom_range(2) != 0) begin
        r = $urandom_range(9);
        set_issue(r < 6 ? 0 : r == 6 ? 1 : r < 9 ? 2 : 3, $urandom_range(31), $urandom,
                  $urandom_range(1), $urandom_range(3) == 0, $urandom);
      end
      for (int p = 0; p < WBP; p++) begin
        if ($urandom_range(1) != 0) begin
          int id;
          if (q.size() > 0 && $urandom_range(4) != 0) id = q[$urandom_range(q.size() - 1)].id;
          else id = $urandom_range(15);
          set_wb(p, id, $urandom, $urandom_range(1), $urandom);
        end
      end
      qry1_id = (q.size() > 0 && $urandom_range(1) != 0) ? 4'(q[$urandom_range(q.size() - 1)].id)
                                                        : 4'($urandom_range(15));
      qry2_id = 4'($urandom_range(15));
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
